// File: rtl/im_port_arbiter_pkg.sv
// rtl/im_port_arbiter_pkg.sv - shared types and default sizes for the IM port arbiter
package im_arb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 10;

  localparam int DEF_MAX_WAIT = 4;
  localparam int WAIT_W       = 4;

  typedef enum logic {BOOT, RUN} arb_state_t;
  typedef enum logic [1:0] {NONE, IF, LD} rd_owner_t;

endpackage

// File: rtl/im_port_arbiter_if.sv
// rtl/im_port_arbiter_if.sv - requester and IM-side signals of the arbiter
// ld_err exists only when IM_WRITE_PROTECT_EN is defined.
interface im_port_arbiter_if
  import im_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_done;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              cpu_hold;
  logic              IM_enable;
  logic              IM_write;
  logic [ADDR_W-1:0] IM_address;
  logic [DATA_W-1:0] IM_in;
  logic [DATA_W-1:0] IM_out;
`ifdef IM_WRITE_PROTECT_EN
  logic              ld_err;
`endif

  // slave is the arbiter's view; master is the requester/IM side
  modport slave (
`ifdef IM_WRITE_PROTECT_EN
    output ld_err,
`endif
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, IM_out,
    output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, cpu_hold,
    output IM_enable, IM_write, IM_address, IM_in
  );

  modport master (
`ifdef IM_WRITE_PROTECT_EN
    input  ld_err,
`endif
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, IM_out,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, cpu_hold,
    input  IM_enable, IM_write, IM_address, IM_in
  );
endinterface

// File: rtl/im_port_arbiter_wait_ctr.sv
// rtl/im_port_arbiter_wait_ctr.sv - saturating count of consecutive denied loader cycles
module im_arb_wait_ctr
  import im_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == MAX_CNT);
endmodule

// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - BOOT/RUN arbiter sharing the instruction memory between fetch and loader
// Optional IM_WRITE_PROTECT_EN rejects loader writes in RUN and flags them on ld_err.
module im_port_arbiter
  import im_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input logic clk,
  input logic rst,
  im_port_arbiter_if.slave bus
);
  arb_state_t        r_state, w_state_next;
  rd_owner_t         r_rd_owner, w_rd_owner_next;
  logic              w_if_gnt, w_ld_gnt, w_reject, w_expired;
  logic              w_im_enable, w_im_write;
  logic [ADDR_W-1:0] w_im_address;
  logic [DATA_W-1:0] w_im_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_rd_owner <= NONE;
    end else begin
      r_state    <= w_state_next;
      r_rd_owner <= w_rd_owner_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_if_gnt     = 1'b0;
    w_ld_gnt     = 1'b0;
    case (r_state)
      BOOT: begin
        w_ld_gnt = bus.ld_req;
        if (bus.ld_done) w_state_next = RUN;
      end
      RUN: begin
        if (bus.ld_req && w_expired) w_ld_gnt = 1'b1;
        else if (bus.if_req)         w_if_gnt = 1'b1;
        else if (bus.ld_req)         w_ld_gnt = 1'b1;
      end
    endcase
  end

  im_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .inc     ((r_state == RUN) && bus.ld_req && !w_ld_gnt),
    .clr     (w_ld_gnt || !bus.ld_req),
    .expired (w_expired)
  );

`ifdef IM_WRITE_PROTECT_EN
  logic r_ld_err;

  // a rejected write is still granted so the loader retires it, but never reaches the IM
  assign w_reject = w_ld_gnt && bus.ld_we && (r_state == RUN);

  always_ff @(posedge clk) begin
    if (!rst) r_ld_err <= 1'b0;
    else      r_ld_err <= w_reject;
  end

  assign bus.ld_err = r_ld_err;
`else
  assign w_reject = 1'b0;
`endif

  always_comb begin
    w_im_enable     = 1'b0;
    w_im_write      = 1'b0;
    w_im_address    = '0;
    w_im_in         = '0;
    w_rd_owner_next = NONE;
    if (w_if_gnt) begin
      w_im_enable     = 1'b1;
      w_im_address    = bus.if_addr;
      w_rd_owner_next = IF;
    end else if (w_ld_gnt && !w_reject) begin
      w_im_enable  = 1'b1;
      w_im_write   = bus.ld_we;
      w_im_address = bus.ld_addr;
      w_im_in      = bus.ld_wdata;
      if (!bus.ld_we) w_rd_owner_next = LD;
    end
  end

  assign bus.if_gnt     = w_if_gnt;
  assign bus.ld_gnt     = w_ld_gnt;
  assign bus.IM_enable  = w_im_enable;
  assign bus.IM_write   = w_im_write;
  assign bus.IM_address = w_im_address;
  assign bus.IM_in      = w_im_in;
  assign bus.cpu_hold   = (r_state == BOOT);

  // gating with rst drops a pending return as soon as reset is asserted
  assign bus.if_rvalid = rst && (r_rd_owner == IF);
  assign bus.ld_rvalid = rst && (r_rd_owner == LD);
  assign bus.if_rdata  = bus.if_rvalid ? bus.IM_out : '0;
  assign bus.ld_rdata  = bus.ld_rvalid ? bus.IM_out : '0;
endmodule

// File: tb/tb_im_port_arbiter.sv
// tb/tb_im_port_arbiter.sv - directed self-checking bench for im_port_arbiter
module tb_im_port_arbiter;
  import im_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [DEF_DATA_W-1:0] mem [0:(1<<DEF_ADDR_W)-1];

  im_port_arbiter_if ifc ();

  im_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // single-port IM with one-cycle registered read
  always @(posedge clk) begin
    if (ifc.IM_enable) begin
      if (ifc.IM_write) mem[ifc.IM_address] <= ifc.IM_in;
      else              ifc.IM_out <= mem[ifc.IM_address];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    tests++; if (ifc.cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold: got %b want 1", ifc.cpu_hold); end
    tests++; if (ifc.if_rvalid !== 1'b0) begin fails++; $display("FAIL reset_if_rvalid: got %b want 0", ifc.if_rvalid); end
    tests++; if (ifc.ld_rvalid !== 1'b0) begin fails++; $display("FAIL reset_ld_rvalid: got %b want 0", ifc.ld_rvalid); end
    tests++; if (ifc.IM_enable !== 1'b0) begin fails++; $display("FAIL reset_im_enable: got %b want 0", ifc.IM_enable); end
    tests++; if (dut.u_wait.r_cnt !== 4'd0) begin fails++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.u_wait.r_cnt); end
  endtask

  task automatic test_boot_load();
    ifc.if_req = 1'b1; ifc.if_addr = 10'd5;
    ifc.ld_req = 1'b1; ifc.ld_we = 1'b1; ifc.ld_addr = 10'd0; ifc.ld_wdata = 32'h0000_0013;
    #1;
    tests++; if (ifc.if_gnt !== 1'b0) begin fails++; $display("FAIL boot0_if_gnt: got %b want 0", ifc.if_gnt); end
    tests++; if (ifc.ld_gnt !== 1'b1) begin fails++; $display("FAIL boot0_ld_gnt: got %b want 1", ifc.ld_gnt); end
    tests++; if ({ifc.IM_enable, ifc.IM_write} !== 2'b11) begin fails++; $display("FAIL boot0_strobes: got %b want 11", {ifc.IM_enable, ifc.IM_write}); end
    tests++; if (ifc.IM_address !== 10'd0) begin fails++; $display("FAIL boot0_addr: got %h want 0", ifc.IM_address); end
    tests++; if (ifc.IM_in !== 32'h0000_0013) begin fails++; $display("FAIL boot0_data: got %h want 00000013", ifc.IM_in); end
    tests++; if (ifc.cpu_hold !== 1'b1) begin fails++; $display("FAIL boot0_cpu_hold: got %b want 1", ifc.cpu_hold); end
    step();
    ifc.ld_addr = 10'd1; ifc.ld_wdata = 32'h0010_0093;
    #1;
    tests++; if (ifc.if_gnt !== 1'b0) begin fails++; $display("FAIL boot1_if_gnt: got %b want 0", ifc.if_gnt); end
    tests++; if ({ifc.IM_enable, ifc.IM_write} !== 2'b11) begin fails++; $display("FAIL boot1_strobes: got %b want 11", {ifc.IM_enable, ifc.IM_write}); end
    tests++; if (ifc.IM_address !== 10'd1) begin fails++; $display("FAIL boot1_addr: got %h want 1", ifc.IM_address); end
    tests++; if (ifc.IM_in !== 32'h0010_0093) begin fails++; $display("FAIL boot1_data: got %h want 00100093", ifc.IM_in); end
    step();
    ifc.ld_req = 1'b0;
    #1;
    tests++; if ({ifc.if_gnt, ifc.IM_enable} !== 2'b00) begin fails++; $display("FAIL boot_idle: got %b want 00", {ifc.if_gnt, ifc.IM_enable}); end
    tests++; if (ifc.cpu_hold !== 1'b1) begin fails++; $display("FAIL boot_idle_cpu_hold: got %b want 1", ifc.cpu_hold); end
    step();
  endtask

  task automatic test_ld_done();
    ifc.if_req = 1'b1; ifc.if_addr = 10'd0;
    ifc.ld_req = 1'b1; ifc.ld_we = 1'b0; ifc.ld_addr = 10'd1; ifc.ld_done = 1'b1;
    #1;
    tests++; if ({ifc.ld_gnt, ifc.if_gnt} !== 2'b10) begin fails++; $display("FAIL done_gnts: got %b want 10", {ifc.ld_gnt, ifc.if_gnt}); end
    tests++; if (ifc.cpu_hold !== 1'b1) begin fails++; $display("FAIL done_cpu_hold_same: got %b want 1", ifc.cpu_hold); end
    step();
    ifc.if_req = 1'b0; ifc.ld_req = 1'b0; ifc.ld_done = 1'b0;
    #1;
    tests++; if (ifc.cpu_hold !== 1'b0) begin fails++; $display("FAIL done_cpu_hold_next: got %b want 0", ifc.cpu_hold); end
    tests++; if (ifc.ld_rvalid !== 1'b1) begin fails++; $display("FAIL done_ld_rvalid: got %b want 1", ifc.ld_rvalid); end
    tests++; if (ifc.ld_rdata !== 32'h0010_0093) begin fails++; $display("FAIL done_ld_rdata: got %h want 00100093", ifc.ld_rdata); end
    step();
  endtask

  task automatic test_fetch_back_to_back();
    ifc.if_req = 1'b1; ifc.if_addr = 10'd0;
    #1;
    tests++; if ({ifc.if_gnt, ifc.IM_enable, ifc.IM_write} !== 3'b110) begin fails++; $display("FAIL b2b_gnt0: got %b want 110", {ifc.if_gnt, ifc.IM_enable, ifc.IM_write}); end
    step();
    ifc.if_addr = 10'd1;
    #1;
    tests++; if (ifc.if_rvalid !== 1'b1) begin fails++; $display("FAIL b2b_rvalid0: got %b want 1", ifc.if_rvalid); end
    tests++; if (ifc.if_rdata !== 32'h0000_0013) begin fails++; $display("FAIL b2b_rdata0: got %h want 00000013", ifc.if_rdata); end
    tests++; if ({ifc.ld_rvalid, ifc.ld_rdata} !== 33'd0) begin fails++; $display("FAIL b2b_ld_idle: got %h want 0", {ifc.ld_rvalid, ifc.ld_rdata}); end
    tests++; if (ifc.IM_address !== 10'd1) begin fails++; $display("FAIL b2b_addr1: got %h want 1", ifc.IM_address); end
    step();
    ifc.if_req = 1'b0;
    #1;
    tests++; if (ifc.if_rvalid !== 1'b1) begin fails++; $display("FAIL b2b_rvalid1: got %b want 1", ifc.if_rvalid); end
    tests++; if (ifc.if_rdata !== 32'h0010_0093) begin fails++; $display("FAIL b2b_rdata1: got %h want 00100093", ifc.if_rdata); end
    step();
    #1;
    tests++; if ({ifc.if_rvalid, ifc.if_rdata} !== 33'd0) begin fails++; $display("FAIL b2b_drain: got %h want 0", {ifc.if_rvalid, ifc.if_rdata}); end
  endtask

  task automatic test_starvation();
    ifc.if_req = 1'b1; ifc.if_addr = 10'd0;
    ifc.ld_req = 1'b1; ifc.ld_we = 1'b0; ifc.ld_addr = 10'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if ({ifc.if_gnt, ifc.ld_gnt} !== 2'b10) begin fails++; $display("FAIL starve_gnts_t%0d: got %b want 10", k, {ifc.if_gnt, ifc.ld_gnt}); end
      tests++; if (dut.u_wait.r_cnt !== 4'(k)) begin fails++; $display("FAIL starve_cnt_t%0d: got %0d want %0d", k, dut.u_wait.r_cnt, k); end
      step();
    end
    #1;
    tests++; if ({ifc.if_gnt, ifc.ld_gnt} !== 2'b01) begin fails++; $display("FAIL starve_gnts_t4: got %b want 01", {ifc.if_gnt, ifc.ld_gnt}); end
    tests++; if ({ifc.IM_enable, ifc.IM_write, ifc.IM_address} !== {2'b10, 10'd1}) begin fails++; $display("FAIL starve_im_t4: got %h want %h", {ifc.IM_enable, ifc.IM_write, ifc.IM_address}, {2'b10, 10'd1}); end
    tests++; if (ifc.if_rvalid !== 1'b1) begin fails++; $display("FAIL starve_if_rvalid_t4: got %b want 1", ifc.if_rvalid); end
    step();
    ifc.ld_req = 1'b0;
    #1;
    tests++; if (ifc.ld_rvalid !== 1'b1) begin fails++; $display("FAIL starve_ld_rvalid_t5: got %b want 1", ifc.ld_rvalid); end
    tests++; if (ifc.ld_rdata !== 32'h0010_0093) begin fails++; $display("FAIL starve_ld_rdata_t5: got %h want 00100093", ifc.ld_rdata); end
    tests++; if (ifc.if_rvalid !== 1'b0) begin fails++; $display("FAIL starve_if_rvalid_t5: got %b want 0", ifc.if_rvalid); end
    tests++; if (dut.u_wait.r_cnt !== 4'd0) begin fails++; $display("FAIL starve_cnt_t5: got %0d want 0", dut.u_wait.r_cnt); end
    ifc.if_req = 1'b0;
    step();
  endtask

  task automatic test_wait_clear();
    ifc.if_req = 1'b1; ifc.if_addr = 10'd0;
    ifc.ld_req = 1'b1; ifc.ld_we = 1'b0; ifc.ld_addr = 10'd1;
    step();
    step();
    ifc.ld_req = 1'b0;
    #1;
    tests++; if (dut.u_wait.r_cnt !== 4'd2) begin fails++; $display("FAIL clear_cnt_before: got %0d want 2", dut.u_wait.r_cnt); end
    step();
    #1;
    tests++; if (dut.u_wait.r_cnt !== 4'd0) begin fails++; $display("FAIL clear_cnt_after: got %0d want 0", dut.u_wait.r_cnt); end
    ifc.if_req = 1'b0;
    step();
  endtask

`ifdef IM_WRITE_PROTECT_EN
  task automatic test_write_protect();
    ifc.ld_req = 1'b1; ifc.ld_we = 1'b1; ifc.ld_addr = 10'd0; ifc.ld_wdata = 32'hDEAD_BEEF;
    #1;
    tests++; if ({ifc.ld_gnt, ifc.IM_enable, ifc.IM_write} !== 3'b100) begin fails++; $display("FAIL wp_reject: got %b want 100", {ifc.ld_gnt, ifc.IM_enable, ifc.IM_write}); end
    tests++; if (ifc.ld_err !== 1'b0) begin fails++; $display("FAIL wp_err_same: got %b want 0", ifc.ld_err); end
    step();
    ifc.ld_req = 1'b0; ifc.ld_we = 1'b0;
    ifc.if_req = 1'b1; ifc.if_addr = 10'd0;
    #1;
    tests++; if (ifc.ld_err !== 1'b1) begin fails++; $display("FAIL wp_err_pulse: got %b want 1", ifc.ld_err); end
    tests++; if (ifc.if_gnt !== 1'b1) begin fails++; $display("FAIL wp_fetch_gnt: got %b want 1", ifc.if_gnt); end
    step();
    ifc.if_req = 1'b0;
    #1;
    tests++; if (ifc.ld_err !== 1'b0) begin fails++; $display("FAIL wp_err_end: got %b want 0", ifc.ld_err); end
    tests++; if (ifc.if_rdata !== 32'h0000_0013) begin fails++; $display("FAIL wp_readback: got %h want 00000013", ifc.if_rdata); end
    step();
  endtask
`else
  task automatic test_run_write();
    ifc.ld_req = 1'b1; ifc.ld_we = 1'b1; ifc.ld_addr = 10'd2; ifc.ld_wdata = 32'h0000_0055;
    #1;
    tests++; if ({ifc.ld_gnt, ifc.IM_enable, ifc.IM_write} !== 3'b111) begin fails++; $display("FAIL runwr_strobes: got %b want 111", {ifc.ld_gnt, ifc.IM_enable, ifc.IM_write}); end
    tests++; if (ifc.IM_in !== 32'h0000_0055) begin fails++; $display("FAIL runwr_data: got %h want 00000055", ifc.IM_in); end
    step();
    ifc.ld_we = 1'b0;
    #1;
    tests++; if (ifc.ld_rvalid !== 1'b0) begin fails++; $display("FAIL runwr_no_rvalid: got %b want 0", ifc.ld_rvalid); end
    step();
    ifc.ld_req = 1'b0;
    #1;
    tests++; if ({ifc.ld_rvalid, ifc.ld_rdata} !== {1'b1, 32'h0000_0055}) begin fails++; $display("FAIL runwr_readback: got %h want 100000055", {ifc.ld_rvalid, ifc.ld_rdata}); end
    step();
  endtask
`endif

  task automatic test_reset_mid_read();
    ifc.if_req = 1'b1; ifc.if_addr = 10'd1;
    #1;
    tests++; if (ifc.if_gnt !== 1'b1) begin fails++; $display("FAIL rmr_gnt: got %b want 1", ifc.if_gnt); end
    step();
    rst = 1'b0; ifc.if_req = 1'b0;
    #1;
    tests++; if (ifc.if_rvalid !== 1'b0) begin fails++; $display("FAIL rmr_rvalid_drop: got %b want 0", ifc.if_rvalid); end
    step();
    #1;
    tests++; if (ifc.if_rvalid !== 1'b0) begin fails++; $display("FAIL rmr_rvalid_after: got %b want 0", ifc.if_rvalid); end
    tests++; if (ifc.cpu_hold !== 1'b1) begin fails++; $display("FAIL rmr_cpu_hold: got %b want 1", ifc.cpu_hold); end
    rst = 1'b1; ifc.if_req = 1'b1; ifc.if_addr = 10'd0;
    #1;
    tests++; if ({ifc.if_gnt, ifc.IM_enable} !== 2'b00) begin fails++; $display("FAIL rmr_boot_if_gnt: got %b want 00", {ifc.if_gnt, ifc.IM_enable}); end
    step();
    ifc.if_req = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < (1 << DEF_ADDR_W); a++) mem[a] = '0;
    rst = 1'b0;
    ifc.if_req = 1'b0; ifc.if_addr = '0;
    ifc.ld_req = 1'b0; ifc.ld_we = 1'b0; ifc.ld_addr = '0; ifc.ld_wdata = '0; ifc.ld_done = 1'b0;
    ifc.IM_out = '0;
    step();
    step();
    test_reset();
    rst = 1'b1;
    step();
    test_boot_load();
    test_ld_done();
    test_fetch_back_to_back();
    test_starvation();
    test_wait_clear();
`ifdef IM_WRITE_PROTECT_EN
    test_write_protect();
`else
    test_run_write();
`endif
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
